// File: rtl/fifo_uart_tx.sv
// Drains a byte FIFO onto a UART line: start, DATA_W bits LSB-first, optional even parity, stop.
// FETCH/LOAD add two idle cycles between frames. Define FIFO_UART_TX_PARITY_EN to enable the parity bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [IDX_W-1:0]  idx, idx_n;
  logic [DATA_W-1:0] shift, shift_n;
  logic              bit_end;
  logic              tx_n, rd_en_n, busy_n, done_n;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity, parity_n;
`endif

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shift      <= '0;
      tx         <= 1'b1;
      fifo_rd_en <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      idx        <= idx_n;
      shift      <= shift_n;
      tx         <= tx_n;
      fifo_rd_en <= rd_en_n;
      busy       <= busy_n;
      frame_done <= done_n;
    end
  end

`ifdef FIFO_UART_TX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity <= 1'b0;
    end else begin
      parity <= parity_n;
    end
  end
`endif

  always_comb begin
    state_n = state;
    idx_n   = idx;
    shift_n = shift;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_n = parity;
`endif
    case (state)
      IDLE: begin
        if (tx_enable && !fifo_empty) state_n = FETCH;
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        // Pop issued in FETCH lands on fifo_data this cycle.
        shift_n = fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_n = ^fifo_data;
`endif
        state_n = START;
      end
      START: begin
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        if (bit_end) begin
          shift_n = shift >> 1;
          if (idx == IDX_LAST) begin
            idx_n = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            idx_n = idx + IDX_W'(1);
          end
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_n = STOP;
      end
`endif
      STOP: begin
        if (bit_end) state_n = (tx_enable && !fifo_empty) ? FETCH : IDLE;
      end
      default: state_n = IDLE;
    endcase

    cnt_n = (state_n != state || bit_end || state == IDLE) ? '0 : cnt + CNT_W'(1);

    // Outputs are registered from next-state values so they align with the state register.
    tx_n = 1'b1;
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = 1'b1;
    endcase
    rd_en_n = (state_n == FETCH);
    busy_n  = (state_n != IDLE);
    done_n  = (state_n == STOP) && (cnt_n == CNT_LAST);
  end

endmodule
